// File: rtl/piece_sprite_engine.sv
// Two-stage pipelined chess-piece sprite renderer: window clip, ROM address, transparency key, selection blink.
// Optional blink highlight is compiled in when SPRITE_BLINK_EN is defined.
module piece_sprite_engine #(
   parameter int SPR_W        = 55,
   parameter int SPR_H        = 55,
   parameter int NUM_PIECES   = 12,
   parameter int PIX_BITS     = 4,
   parameter int TRANSP_IDX   = 0,
   parameter int BLINK_FRAMES = 30,
   parameter int ADDR_W       = $clog2(NUM_PIECES*SPR_W*SPR_H)
) (
   input  logic                vga_clk,
   input  logic                reset_n,
   input  logic [9:0]          DrawX,
   input  logic [9:0]          DrawY,
   input  logic [9:0]          offsetX,
   input  logic [9:0]          offsetY,
   input  logic [3:0]          piece_sel,
   input  logic                frame_start,
   input  logic                selected,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [PIX_BITS-1:0] rom_data,
   output logic [PIX_BITS-1:0] pal_idx,
   input  logic [3:0]          pal_r,
   input  logic [3:0]          pal_g,
   input  logic [3:0]          pal_b,
   output logic [3:0]          red,
   output logic [3:0]          green,
   output logic [3:0]          blue,
   output logic                sprite_on
);

   localparam logic [10:0]         W11    = 11'(SPR_W);
   localparam logic [10:0]         H11    = 11'(SPR_H);
   localparam logic [PIX_BITS-1:0] TRANSP = PIX_BITS'(TRANSP_IDX);

   logic [10:0]       x_ext, y_ext, x_lo, y_lo, x_hi, y_hi;
   logic              in_x, in_y, piece_ok, in_win;
   logic [9:0]        dx, dy;
   logic [ADDR_W-1:0] addr_calc;
   logic              s1_in;
   logic              opaque;
   logic              highlight;

   // 11-bit window bounds so offset+size near the right/bottom edge cannot wrap
   always_comb begin
      x_ext    = {1'b0, DrawX};
      y_ext    = {1'b0, DrawY};
      x_lo     = {1'b0, offsetX};
      y_lo     = {1'b0, offsetY};
      x_hi     = x_lo + W11;
      y_hi     = y_lo + H11;
      in_x     = (x_ext >= x_lo) && (x_ext < x_hi);
      in_y     = (y_ext >= y_lo) && (y_ext < y_hi);
      piece_ok = 32'(piece_sel) < 32'(NUM_PIECES);
      in_win   = in_x && in_y && piece_ok;
      dx       = DrawX - offsetX;
      dy       = DrawY - offsetY;
      addr_calc = ADDR_W'(piece_sel) * ADDR_W'(SPR_W*SPR_H)
                + ADDR_W'(dy) * ADDR_W'(SPR_W)
                + ADDR_W'(dx);
      rom_addr = in_win ? addr_calc : '0;
   end

   always_ff @(posedge vga_clk) begin
      if (!reset_n)
         s1_in <= 1'b0;
      else
         s1_in <= in_win;
   end

   always_comb begin
      pal_idx = s1_in ? rom_data : '0;
      opaque  = s1_in && (rom_data != TRANSP);
   end

`ifdef SPRITE_BLINK_EN
   localparam logic PHASE_OFF = 1'b0;
   localparam logic PHASE_ON  = 1'b1;
   localparam int   CNT_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   logic             phase;
   logic [CNT_W-1:0] blink_cnt;

   // Deselect clears immediately and takes priority over a coincident frame pulse
   always_ff @(posedge vga_clk) begin
      if (!reset_n || !selected) begin
         blink_cnt <= '0;
         phase     <= PHASE_OFF;
      end else if (frame_start) begin
         if (blink_cnt == CNT_LAST) begin
            blink_cnt <= '0;
            phase     <= (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   assign highlight = selected && (phase == PHASE_ON);
`else
   localparam int unused_blink_frames = BLINK_FRAMES;
   logic unused_blink_inputs;
   assign unused_blink_inputs = selected ^ frame_start;
   assign highlight = 1'b0;
`endif

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         red       <= 4'h0;
         green     <= 4'h0;
         blue      <= 4'h0;
         sprite_on <= 1'b0;
      end else begin
         sprite_on <= opaque;
         if (opaque && highlight) begin
            red   <= 4'hF;
            green <= 4'hF;
            blue  <= 4'h0;
         end else if (opaque) begin
            red   <= pal_r;
            green <= pal_g;
            blue  <= pal_b;
         end else begin
            red   <= 4'h0;
            green <= 4'h0;
            blue  <= 4'h0;
         end
      end
   end

endmodule

// File: tb/tb_piece_sprite_engine.sv
// Directed bench for piece_sprite_engine: vector table for clip/address/key, plus reset, sweep and blink sequences.
module tb_piece_sprite_engine;

   logic        vga_clk;
   logic        reset_n;
   logic [9:0]  DrawX, DrawY, offsetX, offsetY;
   logic [3:0]  piece_sel;
   logic        frame_start, selected;
   logic [15:0] rom_addr;
   logic [3:0]  rom_data;
   logic [3:0]  pal_idx;
   logic [3:0]  pal_r, pal_g, pal_b;
   logic [3:0]  red, green, blue;
   logic        sprite_on;
   logic [3:0]  rom_fill;

   int total = 0;
   int bad   = 0;
   bit blink_built;

   piece_sprite_engine #(
      .SPR_W(55), .SPR_H(55), .NUM_PIECES(12), .PIX_BITS(4),
      .TRANSP_IDX(0), .BLINK_FRAMES(2), .ADDR_W(16)
   ) dut (
      .vga_clk(vga_clk), .reset_n(reset_n),
      .DrawX(DrawX), .DrawY(DrawY), .offsetX(offsetX), .offsetY(offsetY),
      .piece_sel(piece_sel), .frame_start(frame_start), .selected(selected),
      .rom_addr(rom_addr), .rom_data(rom_data), .pal_idx(pal_idx),
      .pal_r(pal_r), .pal_g(pal_g), .pal_b(pal_b),
      .red(red), .green(green), .blue(blue), .sprite_on(sprite_on)
   );

   always #5 vga_clk = ~vga_clk;

   // Uniform synchronous ROM and a palette that encodes the index in every channel
   always @(posedge vga_clk) rom_data <= rom_fill;
   assign pal_r = pal_idx;
   assign pal_g = pal_idx + 4'd1;
   assign pal_b = pal_idx + 4'd2;

   typedef struct {
      logic [9:0]  dx, dy, ox, oy;
      logic [3:0]  piece, fill;
      logic [15:0] addr;
      logic        on;
      logic [3:0]  r, g, b;
   } vec_t;

   vec_t vecs[14];

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkColour(input string name, input logic on, input logic [3:0] r,
                              input logic [3:0] g, input logic [3:0] b);
      checkOutput({name, "_on"}, {15'd0, sprite_on}, {15'd0, on});
      checkOutput({name, "_r"}, {12'd0, red}, {12'd0, r});
      checkOutput({name, "_g"}, {12'd0, green}, {12'd0, g});
      checkOutput({name, "_b"}, {12'd0, blue}, {12'd0, b});
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge vga_clk);
      DrawX = v.dx; DrawY = v.dy; offsetX = v.ox; offsetY = v.oy;
      piece_sel = v.piece; rom_fill = v.fill;
      #1;
      checkOutput("vec_addr", rom_addr, v.addr);
      repeat (2) @(posedge vga_clk);
      @(negedge vga_clk);
   endtask

   task automatic sweepRow(input logic [9:0] ox, input int x0, input int x1);
      bit exp_on;
      offsetX = ox; offsetY = 10'd0; DrawY = 10'd0; piece_sel = 4'd0; rom_fill = 4'd5;
      for (int x = x0; x <= x1 + 2; x++) begin
         @(negedge vga_clk);
         if (x >= x0 + 2) begin
            exp_on = ((x - 2) >= int'(ox)) && ((x - 2) < int'(ox) + 55);
            checkOutput("sweep_on", {15'd0, sprite_on}, {15'd0, exp_on});
            checkOutput("sweep_red", {12'd0, red}, exp_on ? 16'd5 : 16'd0);
         end
         if (x <= x1) DrawX = 10'(x);
      end
   endtask

   task automatic pulseFrame();
      @(negedge vga_clk) frame_start = 1'b1;
      @(negedge vga_clk) frame_start = 1'b0;
      @(negedge vga_clk);
   endtask

   task automatic checkBlink(input string name, input bit hl);
      if (hl && blink_built) checkColour(name, 1'b1, 4'hF, 4'hF, 4'h0);
      else                   checkColour(name, 1'b1, 4'h1, 4'h2, 4'h3);
   endtask

   initial begin
      bit hl_seq[8];
`ifdef SPRITE_BLINK_EN
      blink_built = 1'b1;
`else
      blink_built = 1'b0;
`endif
      hl_seq = '{0, 0, 1, 1, 0, 0, 1, 1};

      vecs[0]  = '{10'd101,  10'd102,  10'd100,  10'd100,  4'd3,  4'd5,  16'd9186,  1'b1, 4'd5,  4'd6,  4'd7};
      vecs[1]  = '{10'd0,    10'd0,    10'd0,    10'd0,    4'd0,  4'd5,  16'd0,     1'b1, 4'd5,  4'd6,  4'd7};
      vecs[2]  = '{10'd54,   10'd54,   10'd0,    10'd0,    4'd0,  4'd5,  16'd3024,  1'b1, 4'd5,  4'd6,  4'd7};
      vecs[3]  = '{10'd55,   10'd0,    10'd0,    10'd0,    4'd0,  4'd5,  16'd0,     1'b0, 4'd0,  4'd0,  4'd0};
      vecs[4]  = '{10'd0,    10'd55,   10'd0,    10'd0,    4'd0,  4'd5,  16'd0,     1'b0, 4'd0,  4'd0,  4'd0};
      vecs[5]  = '{10'd101,  10'd102,  10'd100,  10'd100,  4'd12, 4'd5,  16'd0,     1'b0, 4'd0,  4'd0,  4'd0};
      vecs[6]  = '{10'd101,  10'd102,  10'd100,  10'd100,  4'd15, 4'd5,  16'd0,     1'b0, 4'd0,  4'd0,  4'd0};
      vecs[7]  = '{10'd101,  10'd102,  10'd100,  10'd100,  4'd3,  4'd0,  16'd9186,  1'b0, 4'd0,  4'd0,  4'd0};
      vecs[8]  = '{10'd1023, 10'd1023, 10'd1000, 10'd1000, 4'd11, 4'd9,  16'd34563, 1'b1, 4'd9,  4'd10, 4'd11};
      vecs[9]  = '{10'd99,   10'd100,  10'd100,  10'd100,  4'd0,  4'd5,  16'd0,     1'b0, 4'd0,  4'd0,  4'd0};
      vecs[10] = '{10'd154,  10'd154,  10'd100,  10'd100,  4'd1,  4'd7,  16'd6049,  1'b1, 4'd7,  4'd8,  4'd9};
      vecs[11] = '{10'd100,  10'd155,  10'd100,  10'd100,  4'd2,  4'd5,  16'd0,     1'b0, 4'd0,  4'd0,  4'd0};
      vecs[12] = '{10'd30,   10'd25,   10'd10,   10'd20,   4'd2,  4'd15, 16'd6345,  1'b1, 4'd15, 4'd0,  4'd1};
      vecs[13] = '{10'd100,  10'd99,   10'd100,  10'd100,  4'd0,  4'd5,  16'd0,     1'b0, 4'd0,  4'd0,  4'd0};

      vga_clk = 1'b0; reset_n = 1'b0; frame_start = 1'b0; selected = 1'b0;
      DrawX = 10'd101; DrawY = 10'd102; offsetX = 10'd100; offsetY = 10'd100;
      piece_sel = 4'd3; rom_fill = 4'd5;

      $display("[TB] reset from power-up");
      repeat (3) @(posedge vga_clk);
      @(negedge vga_clk);
      checkColour("reset_hold", 1'b0, 4'h0, 4'h0, 4'h0);
      reset_n = 1'b1;
      @(negedge vga_clk);
      checkColour("reset_rel1", 1'b0, 4'h0, 4'h0, 4'h0);
      @(negedge vga_clk);
      checkColour("reset_rel2", 1'b1, 4'h5, 4'h6, 4'h7);

      $display("[TB] mid-frame reset");
      reset_n = 1'b0;
      repeat (3) @(negedge vga_clk);
      checkColour("midreset_hold", 1'b0, 4'h0, 4'h0, 4'h0);
      reset_n = 1'b1;
      @(negedge vga_clk);
      checkColour("midreset_rel1", 1'b0, 4'h0, 4'h0, 4'h0);
      @(negedge vga_clk);
      checkColour("midreset_rel2", 1'b1, 4'h5, 4'h6, 4'h7);

      $display("[TB] vector table");
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i]);
         checkColour($sformatf("vec%0d", i), vecs[i].on, vecs[i].r, vecs[i].g, vecs[i].b);
      end

      $display("[TB] clipping sweeps");
      sweepRow(10'd0, 0, 60);
      sweepRow(10'd600, 0, 700);

      $display("[TB] blink sequence");
      applyStimulus('{10'd101, 10'd102, 10'd100, 10'd100, 4'd3, 4'd1, 16'd9186, 1'b1, 4'd1, 4'd2, 4'd3});
      selected = 1'b1;
      repeat (2) @(negedge vga_clk);
      checkBlink("frame0", hl_seq[0]);
      for (int f = 1; f < 8; f++) begin
         pulseFrame();
         checkBlink($sformatf("frame%0d", f), hl_seq[f]);
      end
      selected = 1'b0;
      @(negedge vga_clk);
      checkBlink("deselect", 1'b0);
      selected = 1'b1;
      @(negedge vga_clk);
      checkBlink("reselect", 1'b0);
      pulseFrame();
      checkBlink("cleared_cnt", 1'b0);
      pulseFrame();
      checkBlink("rewrap", 1'b1);

      selected = 1'b0; frame_start = 1'b1;
      @(negedge vga_clk);
      selected = 1'b1; frame_start = 1'b0;
      @(negedge vga_clk);
      checkBlink("clear_wins", 1'b0);
      pulseFrame();
      pulseFrame();
      checkBlink("hl_again", 1'b1);
      rom_fill = 4'd0;
      repeat (2) @(negedge vga_clk);
      checkColour("hl_transp", 1'b0, 4'h0, 4'h0, 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
